// File: rtl/pmips_l0_core.sv
// pmips_l0_core: 16-bit five-stage MIPS-subset core without forwarding or interlocks.
// Branches and jumps resolve in ID and always execute exactly one delay slot.
module pmips_l0_core (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] imemaddr,
    input  logic [15:0] imemrdata,
    output logic [15:0] dmemaddr,
    output logic [15:0] dmemwdata,
    output logic        dmemwrite,
    output logic        dmemread,
    input  logic [15:0] dmemrdata,
    output logic [15:0] aluresult
);
    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_NONE
    } alu_op_t;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_J     = 3'd2;
    localparam logic [2:0] OP_LW    = 3'd4;
    localparam logic [2:0] OP_SW    = 3'd5;
    localparam logic [2:0] OP_BEQ   = 3'd6;
    localparam logic [2:0] OP_ADDI  = 3'd7;

    logic [15:0] pc, pc_plus2, next_pc;
    logic [15:0] rf [0:7];

    logic [15:0] if_id_instr, if_id_pc2;

    logic [15:0] id_ex_a, id_ex_b, id_ex_imm;
    alu_op_t     id_ex_aluop;
    logic        id_ex_alusrc, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_memtoreg;
    logic [2:0]  id_ex_dest;

    logic [15:0] ex_mem_alu, ex_mem_b;
    logic        ex_mem_regwrite, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;
    logic [2:0]  ex_mem_dest;

    logic [15:0] mem_wb_alu, mem_wb_load;
    logic        mem_wb_regwrite, mem_wb_memtoreg;
    logic [2:0]  mem_wb_dest;

    logic [2:0]  id_op, id_rs, id_rt, id_rd;
    logic [3:0]  id_funct;
    logic [15:0] id_imm, rs_val, rt_val, wb_data;
    logic        wb_en;

    alu_op_t     d_aluop;
    logic        d_alusrc, d_regwrite, d_memread, d_memwrite, d_memtoreg;
    logic [2:0]  d_dest;

    logic [15:0] alu_b, alu_out;

    assign id_op    = if_id_instr[15:13];
    assign id_rs    = if_id_instr[12:10];
    assign id_rt    = if_id_instr[9:7];
    assign id_rd    = if_id_instr[6:4];
    assign id_funct = if_id_instr[3:0];
    assign id_imm   = {{9{if_id_instr[6]}}, if_id_instr[6:0]};

    assign wb_data = mem_wb_memtoreg ? mem_wb_load : mem_wb_alu;
    assign wb_en   = mem_wb_regwrite && (mem_wb_dest != 3'd0);

    // Write-through: a register being written back this cycle reads as its new value.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (id_rs != 3'd0)
            rs_val = (wb_en && mem_wb_dest == id_rs) ? wb_data : rf[id_rs];
        if (id_rt != 3'd0)
            rt_val = (wb_en && mem_wb_dest == id_rt) ? wb_data : rf[id_rt];
    end

    assign pc_plus2 = pc + 16'd2;

    always_comb begin
        next_pc = pc_plus2;
        if (id_op == OP_J)
            next_pc = {if_id_pc2[15:14], if_id_instr[12:0], 1'b0};
        else if (id_op == OP_BEQ && rs_val == rt_val)
            next_pc = if_id_pc2 + {id_imm[14:0], 1'b0};
    end

    always_comb begin
        d_aluop    = ALU_NONE;
        d_alusrc   = 1'b0;
        d_regwrite = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_dest     = id_rd;
        case (id_op)
            OP_RTYPE: begin
                d_regwrite = 1'b1;
                case (id_funct)
                    4'd0:    d_aluop = ALU_ADD;
                    4'd1:    d_aluop = ALU_SUB;
                    4'd2:    d_aluop = ALU_AND;
                    4'd3:    d_aluop = ALU_OR;
                    4'd4:    d_aluop = ALU_SLT;
                    default: d_regwrite = 1'b0;
                endcase
            end
            OP_LW: begin
                d_aluop    = ALU_ADD;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                d_memread  = 1'b1;
                d_memtoreg = 1'b1;
                d_dest     = id_rt;
            end
            OP_SW: begin
                d_aluop    = ALU_ADD;
                d_alusrc   = 1'b1;
                d_memwrite = 1'b1;
            end
            OP_ADDI: begin
                d_aluop    = ALU_ADD;
                d_alusrc   = 1'b1;
                d_regwrite = 1'b1;
                d_dest     = id_rt;
            end
            default: ;
        endcase
    end

    assign alu_b = id_ex_alusrc ? id_ex_imm : id_ex_b;

    always_comb begin
        alu_out = '0;
        case (id_ex_aluop)
            ALU_ADD: alu_out = id_ex_a + alu_b;
            ALU_SUB: alu_out = id_ex_a - alu_b;
            ALU_AND: alu_out = id_ex_a & alu_b;
            ALU_OR:  alu_out = id_ex_a | alu_b;
            ALU_SLT: alu_out = {15'd0, $signed(id_ex_a) < $signed(alu_b)};
            default: alu_out = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc              <= '0;
            if_id_instr     <= '0;
            if_id_pc2       <= '0;
            id_ex_a         <= '0;
            id_ex_b         <= '0;
            id_ex_imm       <= '0;
            id_ex_aluop     <= ALU_NONE;
            id_ex_alusrc    <= 1'b0;
            id_ex_regwrite  <= 1'b0;
            id_ex_memread   <= 1'b0;
            id_ex_memwrite  <= 1'b0;
            id_ex_memtoreg  <= 1'b0;
            id_ex_dest      <= '0;
            ex_mem_alu      <= '0;
            ex_mem_b        <= '0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            ex_mem_memtoreg <= 1'b0;
            ex_mem_dest     <= '0;
            mem_wb_alu      <= '0;
            mem_wb_load     <= '0;
            mem_wb_regwrite <= 1'b0;
            mem_wb_memtoreg <= 1'b0;
            mem_wb_dest     <= '0;
            rf              <= '{default: '0};
        end else begin
            pc              <= next_pc;
            if_id_instr     <= imemrdata;
            if_id_pc2       <= pc_plus2;
            id_ex_a         <= rs_val;
            id_ex_b         <= rt_val;
            id_ex_imm       <= id_imm;
            id_ex_aluop     <= d_aluop;
            id_ex_alusrc    <= d_alusrc;
            id_ex_regwrite  <= d_regwrite;
            id_ex_memread   <= d_memread;
            id_ex_memwrite  <= d_memwrite;
            id_ex_memtoreg  <= d_memtoreg;
            id_ex_dest      <= d_dest;
            ex_mem_alu      <= alu_out;
            ex_mem_b        <= id_ex_b;
            ex_mem_regwrite <= id_ex_regwrite;
            ex_mem_memread  <= id_ex_memread;
            ex_mem_memwrite <= id_ex_memwrite;
            ex_mem_memtoreg <= id_ex_memtoreg;
            ex_mem_dest     <= id_ex_dest;
            mem_wb_alu      <= ex_mem_alu;
            mem_wb_load     <= dmemrdata;
            mem_wb_regwrite <= ex_mem_regwrite;
            mem_wb_memtoreg <= ex_mem_memtoreg;
            mem_wb_dest     <= ex_mem_dest;
            if (wb_en)
                rf[mem_wb_dest] <= wb_data;
        end
    end

    // Reset masks the outputs so an in-flight store cannot hit memory on the reset edge.
    assign imemaddr  = reset ? 16'd0 : pc;
    assign aluresult = reset ? 16'd0 : alu_out;
    assign dmemwrite = ex_mem_memwrite & ~reset;
    assign dmemread  = ex_mem_memread & ~reset;
    assign dmemaddr  = ex_mem_alu;
    assign dmemwdata = ex_mem_b;
endmodule

// File: tb/tb_pmips_l0_core.sv
// Scoreboard bench for pmips_l0_core: an ISA-level interpreter predicts fetch order,
// EX-stage ALU values and MEM-stage memory traffic for directed and random programs.
module tb_pmips_l0_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imemaddr, imemrdata, dmemaddr, dmemwdata, dmemrdata, aluresult;
    logic        dmemwrite, dmemread;

    pmips_l0_core dut (
        .clock(clock), .reset(reset),
        .imemaddr(imemaddr), .imemrdata(imemrdata),
        .dmemaddr(dmemaddr), .dmemwdata(dmemwdata),
        .dmemwrite(dmemwrite), .dmemread(dmemread),
        .dmemrdata(dmemrdata), .aluresult(aluresult)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] pc;
        logic        alu_v;
        logic [15:0] alu;
        logic        mw;
        logic        mr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } exp_t;

    exp_t q_fetch[$], q_ex[$], q_mem[$];

    logic [15:0] imem [0:32767];
    logic [15:0] dmem [0:255];
    logic        dmem_clr = 1'b0;

    assign imemrdata = imem[imemaddr[15:1]];
    assign dmemrdata = dmem[dmemaddr[7:0]];

    always @(posedge clock) begin
        if (dmem_clr) begin
            for (int i = 0; i < 256; i++) dmem[i] <= '0;
        end else if (dmemwrite) begin
            dmem[dmemaddr[7:0]] <= dmemwdata;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic run    = 1'b0;
    logic [15:0] alu_log [0:63];
    logic [15:0] pc_log  [0:63];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at time %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: instruction n is fetched in cycle n, in EX in cycle n+2, in MEM in cycle n+3.
    always @(negedge clock) begin
        if (run) begin
            exp_t e;
            if (q_fetch.size() > 0) begin
                e = q_fetch.pop_front();
                chk("fetch_pc", imemaddr, e.pc);
            end
            if (cyc >= 2 && q_ex.size() > 0) begin
                e = q_ex.pop_front();
                if (e.alu_v) chk("ex_alu", aluresult, e.alu);
            end
            if (cyc >= 3 && q_mem.size() > 0) begin
                e = q_mem.pop_front();
                chk("mem_write", {15'd0, dmemwrite}, {15'd0, e.mw});
                chk("mem_read", {15'd0, dmemread}, {15'd0, e.mr});
                if (e.mw || e.mr) chk("mem_addr", dmemaddr, e.addr);
                if (e.mw) chk("mem_wdata", dmemwdata, e.wdata);
            end
            if (cyc < 64) begin
                alu_log[cyc] = aluresult;
                pc_log[cyc]  = imemaddr;
            end
            cyc++;
        end
    end

    // Architectural reference model
    logic [15:0] m_pc, m_tgt;
    logic        m_pend;
    logic [15:0] m_r   [0:7];
    logic [15:0] m_mem [0:255];

    task automatic model_step(output exp_t e);
        logic [15:0] ins, a, b, imm, res, nxt, addr;
        logic [2:0]  op, rs, rt, rd;
        logic [3:0]  fn;
        ins = imem[m_pc[15:1]];
        op  = ins[15:13]; rs = ins[12:10]; rt = ins[9:7]; rd = ins[6:4]; fn = ins[3:0];
        imm = {{9{ins[6]}}, ins[6:0]};
        a   = m_r[rs];
        b   = m_r[rt];
        e   = '0;
        e.pc = m_pc;
        nxt = m_pend ? m_tgt : m_pc + 16'd2;
        m_pend = 1'b0;
        case (op)
            3'd0: if (fn <= 4'd4) begin
                case (fn)
                    4'd0:    res = a + b;
                    4'd1:    res = a - b;
                    4'd2:    res = a & b;
                    4'd3:    res = a | b;
                    default: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                endcase
                e.alu_v = 1'b1; e.alu = res;
                if (rd != 0) m_r[rd] = res;
            end
            3'd2: begin
                m_pend = 1'b1;
                m_tgt  = ((m_pc + 16'd2) & 16'hC000) | {2'b00, ins[12:0], 1'b0};
            end
            3'd4: begin
                addr = a + imm;
                e.alu_v = 1'b1; e.alu = addr; e.mr = 1'b1; e.addr = addr;
                if (rt != 0) m_r[rt] = m_mem[addr[7:0]];
            end
            3'd5: begin
                addr = a + imm;
                e.alu_v = 1'b1; e.alu = addr; e.mw = 1'b1; e.addr = addr; e.wdata = b;
                m_mem[addr[7:0]] = b;
            end
            3'd6: if (a == b) begin
                m_pend = 1'b1;
                m_tgt  = m_pc + 16'd2 + (imm << 1);
            end
            3'd7: begin
                res = a + imm;
                e.alu_v = 1'b1; e.alu = res;
                if (rt != 0) m_r[rt] = res;
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    task automatic push_step();
        exp_t e;
        model_step(e);
        q_fetch.push_back(e);
        q_ex.push_back(e);
        q_mem.push_back(e);
    endtask

    function automatic logic [15:0] r_ins(int rs, int rt, int rd, int fn);
        return {3'd0, 3'(rs), 3'(rt), 3'(rd), 4'(fn)};
    endfunction
    function automatic logic [15:0] i_ins(int op, int rs, int rt, int imm);
        return {3'(op), 3'(rs), 3'(rt), 7'(imm)};
    endfunction
    function automatic logic [15:0] j_ins(int tgt);
        return {3'd2, 13'(tgt)};
    endfunction

    // Source register not written by either of the two previously executed instructions.
    function automatic logic [2:0] pick(input logic [2:0] h1, input logic [2:0] h2);
        logic [2:0] r;
        do r = 3'($urandom_range(0, 7)); while (r != 0 && (r == h1 || r == h2));
        return r;
    endfunction

    task automatic reset_dut();
        run = 1'b0; reset = 1'b1; dmem_clr = 1'b1;
        @(posedge clock); #1;
        dmem_clr = 1'b0;
        @(posedge clock); #1;
        q_fetch.delete(); q_ex.delete(); q_mem.delete();
        for (int i = 0; i < 32768; i++) imem[i] = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_pc = '0; m_pend = 1'b0; m_tgt = '0;
    endtask

    task automatic release_and_wait(input int budget);
        reset = 1'b0; cyc = 0; run = 1'b1;
        for (int i = 0; i < budget && (q_fetch.size() > 0 || q_mem.size() > 0); i++)
            @(posedge clock);
        if (q_fetch.size() > 0 || q_mem.size() > 0) begin
            n_checks++; n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q_mem.size());
        end
        run = 1'b0;
    endtask

    task automatic gen_random(input int n);
        logic [2:0] h1, h2;
        logic       prev_ctl;
        h1 = 0; h2 = 0; prev_ctl = 1'b0;
        for (int k = 0; k < n; k++) begin
            logic [15:0] ins;
            logic [2:0]  rs, rt, rd, dst;
            logic        ctl;
            int          sel, off;
            rs  = pick(h1, h2);
            rt  = pick(h1, h2);
            rd  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 99);
            if (prev_ctl || k >= n - 3) sel = sel % 80;
            dst = 0; ctl = 1'b0;
            if (sel < 35) begin
                ins = r_ins(rs, rt, rd, $urandom_range(0, 4)); dst = rd;
            end else if (sel < 40) begin
                ins = r_ins(rs, rt, rd, $urandom_range(5, 15));
            end else if (sel < 60) begin
                ins = i_ins(7, rs, rd, $urandom_range(0, 127)); dst = rd;
            end else if (sel < 68) begin
                ins = i_ins(4, rs, rd, $urandom_range(0, 127)); dst = rd;
            end else if (sel < 76) begin
                ins = i_ins(5, rs, rt, $urandom_range(0, 15));
            end else if (sel < 80) begin
                ins = {($urandom_range(0, 1) != 0) ? 3'd1 : 3'd3, 13'($urandom)};
            end else if (sel < 92) begin
                if ($urandom_range(0, 9) < 3) rt = rs;
                ins = i_ins(6, rs, rt, $urandom_range(1, 20)); ctl = 1'b1;
            end else begin
                off = $urandom_range(1, 20);
                ins = j_ins(int'((m_pc + 16'd2 + 16'(2 * off)) >> 1) & 32'h1FFF); ctl = 1'b1;
            end
            imem[m_pc[15:1]] = ins;
            push_step();
            h2 = h1; h1 = dst; prev_ctl = ctl;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        reset_dut();
        chk("reset_imemaddr", imemaddr, 16'h0000);
        chk("reset_aluresult", aluresult, 16'h0000);
        chk("reset_dmemwrite", {15'd0, dmemwrite}, 16'd0);
        chk("reset_dmemread", {15'd0, dmemread}, 16'd0);

        // ALU program
        imem[0]  = i_ins(7, 0, 1, 5);
        imem[3]  = i_ins(7, 0, 2, 3);
        imem[6]  = r_ins(1, 2, 3, 0);
        imem[9]  = r_ins(1, 2, 4, 1);
        imem[12] = r_ins(2, 1, 5, 4);
        for (int i = 0; i < 16; i++) push_step();
        release_and_wait(40);
        chk("alu_addi5", alu_log[2], 16'd5);
        chk("alu_addi3", alu_log[5], 16'd3);
        chk("alu_add", alu_log[8], 16'd8);
        chk("alu_sub", alu_log[11], 16'd2);
        chk("alu_slt", alu_log[14], 16'd1);
        chk("fetch_seq", pc_log[3], 16'h0006);

        // Load/store and $0
        reset_dut();
        imem[0]  = i_ins(7, 0, 1, 10);
        imem[3]  = i_ins(5, 0, 1, 4);
        imem[4]  = i_ins(4, 0, 2, 4);
        imem[7]  = i_ins(7, 2, 3, 1);
        imem[8]  = i_ins(7, 0, 0, 7);
        imem[11] = r_ins(0, 1, 4, 0);
        for (int i = 0; i < 14; i++) push_step();
        release_and_wait(40);
        chk("lw_addi", alu_log[9], 16'd11);
        chk("r0_operand", alu_log[13], 16'd10);
        chk("sw_mem", dmem[4], 16'd10);

        // Branch and jump
        reset_dut();
        imem[0]  = i_ins(7, 0, 1, 5);
        imem[1]  = i_ins(7, 0, 2, 3);
        imem[4]  = i_ins(6, 1, 2, 3);
        imem[8]  = i_ins(6, 0, 0, 3);
        imem[9]  = i_ins(7, 0, 3, 9);
        imem[10] = i_ins(7, 0, 5, 1);
        imem[16] = j_ins(16'h40);
        imem[17] = i_ins(7, 0, 4, 4);
        imem[18] = i_ins(7, 0, 6, 6);
        for (int i = 0; i < 20; i++) push_step();
        release_and_wait(50);
        chk("beq_not_taken", pc_log[6], 16'h000C);
        chk("beq_taken", pc_log[10], 16'h0018);
        chk("beq_slot", alu_log[11], 16'd9);
        chk("j_target", pc_log[16], 16'h0080);
        chk("j_slot", alu_log[17], 16'd4);

        // Reset while a store sits in MEM
        reset_dut();
        imem[0] = i_ins(7, 0, 1, 10);
        imem[3] = i_ins(5, 0, 1, 4);
        imem[4] = i_ins(5, 0, 1, 5);
        reset = 1'b0; cyc = 0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 32768; i++) imem[i] = '0;
        @(negedge clock);
        chk("midrst_dmemwrite", {15'd0, dmemwrite}, 16'd0);
        @(posedge clock); #1;
        chk("midrst_imemaddr", imemaddr, 16'h0000);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("midrst_no_store", {15'd0, dmemwrite}, 16'd0);
        end
        chk("midrst_mem4", dmem[4], 16'd0);
        chk("midrst_mem5", dmem[5], 16'd0);

        // Random hazard-respecting programs
        for (int p = 0; p < 3; p++) begin
            reset_dut();
            gen_random(300);
            release_and_wait(340);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pmips_l0_core.md
Name: pmips_l0_core

Overview:
16-bit, 5-stage pipelined (IF/ID/EX/MEM/WB) MIPS-subset processor core with eight 16-bit registers. It fetches from an external combinational instruction memory and loads/stores through an external data memory with memory-mapped I/O. The core is "Level 0": it has no forwarding and no hazard detection, so software schedules around hazards. It is the CPU of the board-level computer and exposes its EX-stage ALU result for debug.

Parameters:
none

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
imemaddr  output  16  PC; byte address of the instruction being fetched
imemrdata  input  16  instruction word at imemaddr, combinational
dmemaddr  output  16  data address from the EX/MEM ALU result
dmemwdata  output  16  store data from the EX/MEM rt value
dmemwrite  output  1  store enable; memory writes on the rising edge
dmemread  output  1  load enable
dmemrdata  input  16  load data, combinational on dmemaddr
aluresult  output  16  combinational ALU output of the EX stage (debug)

Behaviour:
- Instruction formats, bits:
  - R-type: op[15:13] rs[12:10] rt[9:7] rd[6:4] funct[3:0].
  - I-type: op rs rt imm[6:0]; imm is sign-extended.
  - J-type: op target[12:0].
- Opcodes:
  - 0 R-type. funct 0 add, 1 sub, 2 and, 3 or, 4 slt (signed; result 1 or 0). Any other funct is a nop.
  - 2 j: PC = {PC+2[15:14], target, 0}.
  - 4 lw: rt = M[rs+sext(imm)].
  - 5 sw: M[rs+sext(imm)] = rt.
  - 6 beq: if rs==rt, PC = PC+2 + (sext(imm)<<1).
  - 7 addi: rt = rs+sext(imm).
  - Opcodes 1 and 3 are nops. 0x0000 is the canonical nop.
- Arithmetic is mod 2^16; there is no overflow trap.
- $0 always reads 0. Writes to $0 are discarded.
- PC and pipeline:
  - PC advances by 2 per cycle; there are no stalls.
  - IF/ID latches the instruction and PC+2.
  - ID/EX, EX/MEM and MEM/WB carry data plus control: regwrite, memread, memwrite, memtoreg, destination register.
- Branches and jumps resolve in ID, comparing the register-file outputs. The PC loads the target on the next edge.
- There is exactly one delay slot: the instruction fetched after a branch or jump always executes. There is no flush.
- Register file:
  - 2 combinational read ports and 1 write port.
  - WB writes on the rising edge.
  - A read of the register being written in the same cycle returns the new value (internal write-through bypass).
- Hazard contract: a consumer must be at least 3 instructions after its producer (two intervening instructions). This also applies to lw results and to beq operands. Violations read stale values; this is not an error.
- Destination register is rd for R-type, and rt for addi and lw.
- ALU B input is sext(imm) for lw, sw and addi; otherwise rt.
- dmemwrite and dmemread are asserted only while a sw or lw is in MEM. Otherwise both are 0. dmemaddr and dmemwdata may hold arbitrary values when both are 0.
- Reset (synchronous, on a rising edge with reset=1):
  - PC=0.
  - All pipeline registers become nop bubbles with control cleared.
  - All registers cleared to 0.
  - Outputs during reset: imemaddr=0, dmemwrite=0, dmemread=0, aluresult=0.
- Reset asserted mid-program discards all in-flight instructions. No memory write occurs on the reset edge.
- External memory contract: instruction memory is read-only and combinational. Data memory reads are combinational and writes are clocked. I/O addresses are decoded outside the core.

Test Plan:
1. Reset: reset=1 for one edge, then 0 -> imemaddr=0 after the reset edge, then 2, 4, 6 on successive edges. dmemwrite=0 and dmemread=0 throughout a nop-only program.
2. ALU: program 0xE085 (addi $1,$0,5), nop, nop, addi $2,$0,3, nop, nop, add $3,$1,$2, nop, nop, sub $4,$1,$2, nop, nop, slt $5,$2,$1 -> aluresult shows 5, 3, 8, 2, 1 in the EX cycle of each instruction.
3. Load/store: addi $1,$0,10; nop; nop; sw $1,4($0); lw $2,4($0); nop; nop; addi $3,$2,1 -> in the sw MEM cycle dmemwrite=1, dmemaddr=4, dmemwdata=10. In the lw MEM cycle dmemread=1. $3 reaches 11, seen as aluresult=11.
4. Branch: beq $0,$0,+3 at address 0x10 -> the delay-slot instruction at 0x12 executes. The next fetch after it is at 0x18. A not-taken beq (operands 5 and 3) falls through to 0x14.
5. Jump: j target=0x40 at address 0x20 -> the delay slot at 0x22 executes, then imemaddr=0x80.
6. Register $0 and reset mid-run: addi $0,$0,7 followed by add reading $0 -> operand is 0. Asserting reset mid-program -> imemaddr=0 on the next edge and no dmemwrite from in-flight stores.
